// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 64-word data memory: fixed priority to
// port 0 with a starvation override for port 1, IDLE -> ACCESS -> RESP per transaction.
module dmem_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [3:0]          starve_q, starve_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                aerr0_q, aerr0_d, aerr1_q, aerr1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                mrd_q, mrd_d, mwr_q, mwr_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mwdata_q, mwdata_d;

  logic                grant1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_bad;
  logic [DATA_W-1:0]   cap_data;

  assign grant1    = m1_req && (!m0_req || (starve_q == STARVE_LIM));
  assign sel_we    = grant1 ? m1_we    : m0_we;
  assign sel_addr  = grant1 ? m1_addr  : m0_addr;
  assign sel_wdata = grant1 ? m1_wdata : m0_wdata;
  assign sel_bad   = (sel_addr[1:0] != 2'b00) || (|sel_addr[ADDR_W-1:8]);
  assign cap_data  = (!we_q && !err_q) ? mem_rdata : '0;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    err_d    = err_q;
    starve_d = starve_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    aerr0_d  = 1'b0;
    aerr1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    maddr_d  = '0;
    mwdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          win_d    = grant1;
          we_d     = sel_we;
          err_d    = sel_bad;
          maddr_d  = sel_addr;
          mwdata_d = sel_wdata;
          mrd_d    = !sel_we && !sel_bad;
          mwr_d    = sel_we && !sel_bad;
          state_d  = ACCESS;
        end
        // Counter only moves in IDLE: cleared on a port-1 grant or idle port 1.
        if (grant1 || !m1_req)
          starve_d = '0;
        else if (starve_q != STARVE_LIM)
          starve_d = starve_q + 4'd1;
      end
      ACCESS: begin
        state_d = RESP;
        if (win_q) begin
          ack1_d   = 1'b1;
          aerr1_d  = err_q;
          rdata1_d = cap_data;
        end else begin
          ack0_d   = 1'b1;
          aerr0_d  = err_q;
          rdata0_d = cap_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      starve_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      aerr0_q  <= 1'b0;
      aerr1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      err_q    <= err_d;
      starve_q <= starve_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      aerr0_q  <= aerr0_d;
      aerr1_q  <= aerr1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign m0_ack    = ack0_q;
  assign m0_err    = aerr0_q;
  assign m0_rdata  = rdata0_q;
  assign m1_ack    = ack1_q;
  assign m1_err    = aerr1_q;
  assign m1_rdata  = rdata1_q;
  assign mem_read  = mrd_q;
  assign mem_write = mwr_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [64];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on one port: grant, ack, back to IDLE.
  task automatic xact(input string tag, input int port, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    if (port == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
    step();
    chk({tag, " acc_rd"},   32'(mem_read),  32'(!we && !exp_err));
    chk({tag, " acc_wr"},   32'(mem_write), 32'(we && !exp_err));
    chk({tag, " acc_addr"}, mem_addr, addr);
    chk({tag, " acc_ack"},  32'(m0_ack | m1_ack), 32'd0);
    step();
    chk({tag, " ack"},   32'(port == 0 ? m0_ack : m1_ack), 32'd1);
    chk({tag, " other"}, 32'(port == 0 ? m1_ack : m0_ack), 32'd0);
    chk({tag, " err"},   32'(port == 0 ? m0_err : m1_err), 32'(exp_err));
    chk({tag, " rdata"}, (port == 0 ? m0_rdata : m1_rdata), exp_rdata);
    chk({tag, " resp_strobe"}, 32'(mem_read | mem_write), 32'd0);
    if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
    step();
    chk({tag, " idle_ack"}, 32'(m0_ack | m1_ack), 32'd0);
    chk({tag, " idle_strobe"}, 32'(mem_read | mem_write), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    reset_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    step(); step();
    chk("rst m0_ack", 32'(m0_ack), 32'd0);
    chk("rst m1_ack", 32'(m1_ack), 32'd0);
    chk("rst m0_rdata", m0_rdata, 32'd0);
    chk("rst m1_rdata", m1_rdata, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst strobes", 32'(mem_read | mem_write), 32'd0);
    reset_n = 1'b1;
    step();

    // Reset in the middle of a write's ACCESS cycle.
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hCAFE_F00D;
    step();
    chk("midrst pre_wr", 32'(mem_write), 32'd1);
    chk("midrst pre_addr", mem_addr, 32'h10);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst wr", 32'(mem_write), 32'd0);
    chk("midrst addr", mem_addr, 32'd0);
    chk("midrst wdata", mem_wdata, 32'd0);
    m0_req = 0; m0_we = 0;
    step();
    chk("midrst noack", 32'(m0_ack | m1_ack), 32'd0);
    reset_n = 1'b1;
    step();
    xact("midrst readback", 0, 1'b0, 32'h10, 32'd0, 32'hA000_0004, 1'b0);

    xact("p0 write", 0, 1'b1, 32'h04, 32'hDEAD_BEEF, 32'd0, 1'b0);
    xact("p0 read", 0, 1'b0, 32'h04, 32'd0, 32'hDEAD_BEEF, 1'b0);

    xact("p1 unaligned", 1, 1'b0, 32'h06, 32'd0, 32'd0, 1'b1);
    xact("p1 range", 1, 1'b1, 32'h100, 32'h55, 32'd0, 1'b1);

    // Port 0 arrives during port 1's ACCESS, then holds req across its ack.
    m1_req = 1; m1_we = 0; m1_addr = 32'h0C;
    step();
    chk("late p1 acc_rd", 32'(mem_read), 32'd1);
    chk("late p1 acc_addr", mem_addr, 32'h0C);
    m0_req = 1; m0_we = 0; m0_addr = 32'h04;
    step();
    chk("late p1 ack", 32'(m1_ack), 32'd1);
    chk("late p1 rdata", m1_rdata, 32'hA000_0003);
    chk("late p0 noack", 32'(m0_ack), 32'd0);
    m1_req = 0;
    step();
    chk("late idle strobe", 32'(mem_read), 32'd0);
    step();
    chk("late p0 acc_rd", 32'(mem_read), 32'd1);
    chk("late p0 acc_addr", mem_addr, 32'h04);
    step();
    chk("late p0 ack", 32'(m0_ack), 32'd1);
    chk("late p0 rdata", m0_rdata, 32'hDEAD_BEEF);
    step();
    chk("hold idle ack", 32'(m0_ack), 32'd0);
    chk("hold idle strobe", 32'(mem_read), 32'd0);
    step();
    chk("hold acc_rd", 32'(mem_read), 32'd1);
    step();
    chk("hold ack", 32'(m0_ack), 32'd1);
    m0_req = 0;
    step();

    // Both ports requesting continuously: four port-0 grants then one port-1.
    m0_req = 1; m0_we = 0; m0_addr = 32'h00;
    m1_req = 1; m1_we = 0; m1_addr = 32'h08;
    for (int k = 0; k < 10; k++) begin
      step();
      step();
      chk($sformatf("arb%0d m0_ack", k), 32'(m0_ack), 32'((k % 5) != 4));
      chk($sformatf("arb%0d m1_ack", k), 32'(m1_ack), 32'((k % 5) == 4));
      chk($sformatf("arb%0d m0_rdata", k), m0_rdata, 32'hA000_0000);
      if ((k % 5) == 4) chk($sformatf("arb%0d m1_rdata", k), m1_rdata, 32'hA000_0002);
      step();
    end
    m0_req = 0; m1_req = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 64-word data memory. Shares the single memory port between the CPU load/store unit (port 0) and a DMA/debug master (port 1), drives the memory's MemRead/MemWrite/Address/writeData strobes, and returns registered read data with a one-cycle acknowledge. Sits between the requesters and the data memory, with the arbiter as the memory's only driver.

## Interface

- DATA_W, 32, data width of both ports and memory
- ADDR_W, 32, byte-address width
- STARVE_MAX, 4, consecutive port-1 losses before port 1 is force-granted (1..15)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  request, held until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  valid with ack; 1 = rejected address
- m0_rdata / m1_rdata  out  DATA_W  read data, valid with ack
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory writeData
- mem_rdata  in  DATA_W  from memory readData (combinational)

## Operation

- FSM states: IDLE, ACCESS, RESP. Reset enters IDLE.
- IDLE: if any req, arbitrate and latch winner id, we, addr, wdata. Go to ACCESS. Otherwise stay.
- Arbitration: port 0 has fixed priority, with one exception. If m1_req and starve_cnt == STARVE_MAX, port 1 wins.
- starve_cnt (4 bit):
  - increments when port 1 requests and loses;
  - clears when port 1 is granted or m1_req is low in IDLE;
  - saturates at STARVE_MAX.
- Address check at grant:
  - legal only if addr[1:0] == 0 and addr[ADDR_W-1:8] == 0;
  - an illegal address marks the transaction err; no memory strobe is issued.
- ACCESS (one cycle):
  - mem_addr/mem_wdata driven from the latch;
  - mem_read = !we & !err, mem_write = we & !err;
  - on a read, mem_rdata is captured into the winner's rdata register at the end of the cycle;
  - the write commits at the same edge.
- RESP (one cycle): winner's ack = 1, err as latched. rdata holds the captured value, or 0 for a write or an err. Return to IDLE.
- Requester drops req before the IDLE cycle after its ack. A req still high in IDLE is a new transaction.
- Non-winner outputs: ack = 0, err = 0. rdata holds its last value.
- mem_addr, mem_wdata, mem_read and mem_write are 0 outside ACCESS. There is never a simultaneous read and write.
- Reset values: all acks, errs, rdata, mem_* outputs = 0; starve_cnt = 0; state = IDLE.
- Reset asserted mid-transaction: outputs clear immediately (async); the transaction is dropped with no ack; a write in ACCESS does not commit.

## Timing

- Request seen high at edge N (in IDLE): ACCESS during cycle N+1, ack during cycle N+2, next arbitration at edge N+3.
- Throughput: one transaction per 3 cycles. Back-to-back requests from the same port are accepted at the IDLE edge after RESP.
- Read latency: 2 cycles from grant edge to ack.
- Write visibility: a read granted after a write's RESP returns the new data.
- mem_* outputs are registered; there is no combinational path from m*_req to mem_*.

## Test plan

- Reset with reset_n = 0 mid-ACCESS of a write to 0x10 -> all outputs 0 immediately, no ack, and a later read of 0x10 returns its prior value.
- Port 0 writes 0xDEADBEEF to 0x04, then reads 0x04 -> write ack with err = 0 and rdata = 0; read ack 2 cycles after grant with m0_rdata = 0xDEADBEEF; mem_write high for exactly one cycle.
- Both ports request continuously (m0 reads 0x00, m1 reads 0x08) -> grants go port 0 four times then port 1 once, repeating. starve_cnt returns to 0 after each port-1 grant.
- m1 reads 0x06 (unaligned), then m1 writes 0x100 (out of range) -> each gets ack with m1_err = 1 and rdata = 0; mem_read and mem_write stay 0 throughout.
- Port 1 requests alone, and m0_req rises during port 1's ACCESS -> port 1 completes unaffected; port 0 is granted at the next IDLE edge.
- Port 0 keeps req high across its ack -> a second transaction starts at the IDLE edge with no idle gap beyond IDLE.
